// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the lane-parallel half adder.
// Latency: none (package only). Backpressure: not applicable.
package half_adder_pkg;

  localparam int HA_MAX_WIDTH = 64;

  // Width of a count that can hold every value from 0 to w inclusive.
  function automatic int ha_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane gate-level half adder cell: one XOR, one AND.
// Latency: purely combinational. Backpressure: none.
module half_adder_cell (
  input  logic A,
  input  logic B,
  output logic SUM,
  output logic Cout
);

  assign SUM  = A ^ B;
  assign Cout = A & B;

endmodule

// File: rtl/half_adder.sv
// Registered WIDTH-lane half adder; optional Cout popcount under HALF_ADDER_CARRY_CNT_EN.
// Latency: 1 clock from accepted operands to SUM/Cout/out_valid. Backpressure: none.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SUM,
  output logic [WIDTH-1:0] Cout,
`ifdef HALF_ADDER_CARRY_CNT_EN
  output logic [ha_cnt_width(WIDTH)-1:0] carry_cnt,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] cout_c;
  logic [WIDTH-1:0] sum_d,  sum_q;
  logic [WIDTH-1:0] cout_d, cout_q;
  logic             vld_d,  vld_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .A    (A[i]),
      .B    (B[i]),
      .SUM  (sum_c[i]),
      .Cout (cout_c[i])
    );
  end

  // Results only load on accepted operands; otherwise the last result is held.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    vld_d  = in_valid;
    if (in_valid) begin
      sum_d  = sum_c;
      cout_d = cout_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      vld_q  <= vld_d;
    end
  end

  assign SUM       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = vld_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam int CW = ha_cnt_width(WIDTH);

  logic [CW-1:0] cnt_c;
  logic [CW-1:0] cnt_d, cnt_q;

  // Count is taken from the new carries so it lines up with Cout on the same edge.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_c = cnt_c + CW'(cout_c[i]);
    end
    cnt_d = in_valid ? cnt_c : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a 4-lane and a 1-lane instance share clock, reset and in_valid.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a4, b4, sum4, cout4;
  logic       ov4;
  logic       a1, b1, sum1, cout1;
  logic       ov1;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [2:0] cc4;
  logic [0:0] cc1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the outputs must show after the most recent edge.
  logic [3:0] exp_sum4, exp_cout4;
  logic       exp_sum1, exp_cout1, exp_vld;
  int         exp_cnt4, exp_cnt1;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a4),
    .B         (b4),
    .SUM       (sum4),
    .Cout      (cout4),
`ifdef HALF_ADDER_CARRY_CNT_EN
    .carry_cnt (cc4),
`endif
    .out_valid (ov4)
  );

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a1),
    .B         (b1),
    .SUM       (sum1),
    .Cout      (cout1),
`ifdef HALF_ADDER_CARRY_CNT_EN
    .carry_cnt (cc1),
`endif
    .out_valid (ov1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane result from integer addition: {carry, sum} = a + b.
  task automatic ref_add(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] s, output logic [3:0] c, output int n);
    int t;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      t    = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = t >= 2;
      n    = n + (t >= 2 ? 1 : 0);
    end
  endtask

  task automatic model_reset();
    exp_sum4 = '0; exp_cout4 = '0; exp_sum1 = 1'b0; exp_cout1 = 1'b0;
    exp_vld = 1'b0; exp_cnt4 = 0; exp_cnt1 = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sum4"},  64'(sum4),  64'(exp_sum4));
    chk({tag, ".cout4"}, 64'(cout4), 64'(exp_cout4));
    chk({tag, ".vld4"},  64'(ov4),   64'(exp_vld));
    chk({tag, ".sum1"},  64'(sum1),  64'(exp_sum1));
    chk({tag, ".cout1"}, 64'(cout1), 64'(exp_cout1));
    chk({tag, ".vld1"},  64'(ov1),   64'(exp_vld));
`ifdef HALF_ADDER_CARRY_CNT_EN
    chk({tag, ".cnt4"},  64'(cc4),   64'(exp_cnt4));
    chk({tag, ".cnt1"},  64'(cc1),   64'(exp_cnt1));
`endif
  endtask

  // Drive at the falling edge, update the model at the rising edge, sample 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic x, input logic y);
    logic [3:0] s, c, s1, c1;
    int         n, n1;
    @(negedge clk);
    in_valid = v; a4 = a; b4 = b; a1 = x; b1 = y;
    @(posedge clk);
    exp_vld = v;
    if (v) begin
      ref_add(a, b, s, c, n);
      ref_add({3'b0, x}, {3'b0, y}, s1, c1, n1);
      exp_sum4 = s; exp_cout4 = c; exp_cnt4 = n;
      exp_sum1 = s1[0]; exp_cout1 = c1[0]; exp_cnt1 = n1;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic       rv;

    rst_n = 1'b0; in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1;
    model_reset();
    #1;
    check_all("reset_noclk");
    @(posedge clk); #1;
    check_all("reset_clk");
    @(negedge clk);
    rst_n = 1'b1;

    step("tt00", 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    step("tt01", 1'b1, 4'h0, 4'hF, 1'b0, 1'b1);
    step("tt10", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
    step("tt11", 1'b1, 4'hF, 4'hF, 1'b1, 1'b1);
    step("hold", 1'b0, 4'h0, 4'hF, 1'b0, 1'b1);
    step("hold2", 1'b0, 4'h5, 4'h3, 1'b1, 1'b0);
    step("lanes", 1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0);
    step("allc", 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b1);

    // Asynchronous reset between edges after a valid result.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post_reset");
    step("first01", 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = 4'($urandom);
      rb = 4'($urandom);
      step("rand", rv, ra, rb, ra[0] ^ rb[3], rb[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_adder.md
# half_adder

Registered, lane-parallel half adder: each of `WIDTH` independent lanes adds two 1-bit operands and produces a sum bit and a carry bit. It is the basic arithmetic primitive of the gate-level library and sits beneath ripple and full-adder compositions. Results are captured in a register stage with a valid flag, so the block can be dropped into clocked datapaths.

## Interface
- `WIDTH`, default 1: number of independent half-adder lanes; legal range 1..64.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands on `A`/`B` are valid this cycle.
- `A`  input  WIDTH  operand A, one bit per lane.
- `B`  input  WIDTH  operand B, one bit per lane.
- `SUM`  output  WIDTH  registered per-lane sum, `A ^ B`.
- `Cout`  output  WIDTH  registered per-lane carry, `A & B`.
- `out_valid`  output  1  `SUM`/`Cout` hold a result captured on the previous edge.
- `carry_cnt`  output  $clog2(WIDTH+1)  present only with `HALF_ADDER_CARRY_CNT_EN`; number of set bits in `Cout`.

## Operation
- Per lane i: `SUM[i] = A[i] XOR B[i]`, `Cout[i] = A[i] AND B[i]`; lanes never interact.
- Truth table per lane: 00 -> SUM 0, Cout 0; 01 -> 1, 0; 10 -> 1, 0; 11 -> 0, 1.
- Arithmetic identity per lane: `{Cout[i], SUM[i]} = A[i] + B[i]` (2-bit result, never overflows).
- Combinational logic is built from one XOR and one AND per lane (gate-level cell).
- `in_valid` high at an edge: `SUM`/`Cout` load the new results, `out_valid` set to 1.
- `in_valid` low at an edge: `SUM`/`Cout` hold previous values, `out_valid` cleared to 0.
- `A`/`B` changes while `in_valid` is low have no effect on outputs.
- No back-pressure; a result is presented for one cycle per accepted operand set; consumer must sample while `out_valid` is high.

## Timing
- Latency: exactly 1 clock from `in_valid`/operands sampled to `SUM`/`Cout`/`out_valid` update.
- Throughput: one operand set per clock; back-to-back `in_valid` gives back-to-back `out_valid`.
- Reset: `rst_n` low forces `SUM = 0`, `Cout = 0`, `out_valid = 0`, `carry_cnt = 0` immediately, independent of `clk`.
- Reset mid-operation: any in-flight result is discarded; first valid output after deassertion needs an accepted `in_valid` on an edge after `rst_n` returns high.
- Reset deassertion is assumed synchronized to `clk` by the reset controller upstream.

## Configuration
- `HALF_ADDER_CARRY_CNT_EN` defined: `carry_cnt` port and a population-count register exist; it is updated on the same edge as `Cout` with the count of set bits in the new `Cout` value, holds when `in_valid` is low, resets to 0.
- Not defined: `carry_cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `half_adder_pkg`: `HA_MAX_WIDTH = 64` constant and the function computing `carry_cnt` width from `WIDTH`.
- One sub-module, `half_adder_cell`: pure gate-level single-lane XOR/AND cell (inputs `A`, `B`; outputs `SUM`, `Cout`), instantiated `WIDTH` times via generate loop; top level holds only registers and optional counter.

## Test plan
- Reset: hold `rst_n` low with `A=1,B=1,in_valid=1` -> `SUM=0`, `Cout=0`, `out_valid=0` throughout, no clock edge required.
- Exhaustive truth table, WIDTH=1: drive 00, 01, 10, 11 on consecutive cycles with `in_valid=1` -> one cycle later SUM/Cout = 0/0, 1/0, 1/0, 0/1, `out_valid=1` each cycle.
- Hold: after `A=1,B=1` accepted, drop `in_valid`, drive `A=0,B=1` -> `SUM=0,Cout=1` retained, `out_valid=0`.
- Lane independence, WIDTH=4: `A=4'b1100`, `B=4'b1010` -> `SUM=4'b0110`, `Cout=4'b1000`; with macro, `carry_cnt=1`.
- All-carry, WIDTH=4: `A=B=4'b1111` -> `SUM=0`, `Cout=4'b1111`, `carry_cnt=4`.
- Async reset mid-stream: assert `rst_n` low between edges after valid result -> outputs clear immediately; deassert, next accepted `01` yields `SUM=1,Cout=0` one cycle later.
